// File: rtl/dxl_pkg.sv
// Shared constants, parser state encoding and checksum helper for the
// Dynamixel protocol-1.0 status receiver.
package dxl_pkg;

    localparam logic [7:0] DXL_HDR = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        HDR1,
        HDR2,
        ID,
        LEN,
        ERR,
        PARAM,
        CSUM
    } dxl_rx_state_t;

    // Protocol-1.0 checksum: one's complement of the byte sum of ID..last param.
    function automatic logic [7:0] dxl_checksum(input logic [7:0] sum);
        return ~sum;
    endfunction

endpackage

// File: rtl/dxl_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, glitch-checked start detect,
// mid-bit sampling, one-cycle byte / frame-error strobes.
module dxl_uart_rx_byte #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int CW      = $clog2(BIT_CYC);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYC / 2 - 1);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;

    uart_state_t   ust_q, ust_n;
    logic [1:0]    sync_q;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [2:0]    bit_q, bit_n;
    logic [7:0]    shift_q, shift_n;
    logic          valid_q, valid_n;
    logic          ferr_q, ferr_n;
    logic          rxd_s;

    assign rxd_s = sync_q[1];

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            ust_q   <= U_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rxd};
            prev_q  <= rxd_s;
            ust_q   <= ust_n;
            cnt_q   <= cnt_n;
            bit_q   <= bit_n;
            shift_q <= shift_n;
            valid_q <= valid_n;
            ferr_q  <= ferr_n;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        ust_n   = ust_q;
        cnt_n   = cnt_q;
        bit_n   = bit_q;
        shift_n = shift_q;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (ust_q)
            U_IDLE: begin
                if (prev_q && !rxd_s) begin
                    ust_n = U_START;
                    cnt_n = HALF_LAST;
                end
            end
            U_START: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - 1'b1;
                end else if (rxd_s) begin
                    ust_n = U_IDLE;
                end else begin
                    ust_n = U_DATA;
                    cnt_n = BIT_LAST;
                    bit_n = '0;
                end
            end
            U_DATA: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - 1'b1;
                end else begin
                    shift_n = {rxd_s, shift_q[7:1]};
                    cnt_n   = BIT_LAST;
                    bit_n   = bit_q + 3'd1;
                    if (bit_q == 3'd7) ust_n = U_STOP;
                end
            end
            U_STOP: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - 1'b1;
                end else begin
                    ust_n   = U_IDLE;
                    valid_n = rxd_s;
                    ferr_n  = !rxd_s;
                end
            end
            default: ust_n = U_IDLE;
        endcase
    end

    assign byte_data  = shift_q;
    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/dxl_status_rx.sv
// Dynamixel protocol-1.0 status-packet receiver: parses FF FF ID LEN ERR P.. CSUM
// after arm. Optional event counters enabled by DXL_STATUS_RX_STATS_EN.
module dxl_status_rx
    import dxl_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BAUD        = 1_000_000,
    parameter int MAX_PARAMS  = 4,
    parameter int TIMEOUT_CYC = 50_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    input  logic        arm,
    output logic        busy,
    output logic        pkt_valid,
    output logic        crc_fail,
    output logic        timeout,
    output logic        frame_err,
    output logic [7:0]  pkt_id,
    output logic [7:0]  pkt_err,
    output logic [2:0]  pkt_nparam,
    output logic [31:0] pkt_params,
    output logic [15:0] stat_good,
    output logic [15:0] stat_bad
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMR_INIT = TW'(TIMEOUT_CYC);
    localparam logic [7:0]    LEN_MAX  = 8'(MAX_PARAMS + 2);

    logic [7:0]    rx_byte;
    logic          rx_valid, rx_ferr;
    dxl_rx_state_t state_q, state_n;
    logic [TW-1:0] tmr_q;
    logic [7:0]    id_q, err_q, sum_q;
    logic [2:0]    nparam_q, idx_q;
    logic [31:0]   scratch_q;
    logic          take, len_ok, good, crc_bad, expire, ld_timer;
    logic          pkt_valid_q, crc_fail_q, timeout_q, frame_err_q;

    dxl_uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .byte_data  (rx_byte),
        .byte_valid (rx_valid),
        .frame_err  (rx_ferr)
    );

    assign busy   = (state_q != IDLE);
    assign take   = rx_valid && !arm && busy;
    assign len_ok = (rx_byte >= 8'd2) && (rx_byte <= LEN_MAX);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n  = state_q;
        ld_timer = 1'b0;
        good     = 1'b0;
        crc_bad  = 1'b0;
        expire   = 1'b0;
        if (arm) begin
            state_n  = HDR1;
            ld_timer = 1'b1;
        end else if (busy) begin
            if (rx_ferr) begin
                state_n = HDR1;
            end else if (rx_valid) begin
                case (state_q)
                    HDR1:  state_n = (rx_byte == DXL_HDR) ? HDR2 : HDR1;
                    HDR2:  state_n = (rx_byte == DXL_HDR) ? ID : HDR1;
                    ID:    if (rx_byte != DXL_HDR) state_n = LEN;
                    LEN:   state_n = len_ok ? ERR : HDR1;
                    ERR:   state_n = (nparam_q != '0) ? PARAM : CSUM;
                    PARAM: if (idx_q + 3'd1 == nparam_q) state_n = CSUM;
                    CSUM: begin
                        good    = (rx_byte == dxl_checksum(sum_q));
                        crc_bad = !good;
                        state_n = IDLE;
                    end
                    default: state_n = IDLE;
                endcase
            end
            // A finishing packet takes precedence over a coincident expiry.
            if (tmr_q == TW'(1) && !good && !crc_bad) begin
                expire  = 1'b1;
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the parameter scratch buffer is reset like any other register so a fresh part never exposes stale bytes.
        if (reset) begin
            tmr_q       <= '0;
            id_q        <= '0;
            err_q       <= '0;
            sum_q       <= '0;
            nparam_q    <= '0;
            idx_q       <= '0;
            scratch_q   <= '0;
            pkt_valid_q <= 1'b0;
            crc_fail_q  <= 1'b0;
            timeout_q   <= 1'b0;
            frame_err_q <= 1'b0;
            pkt_id      <= '0;
            pkt_err     <= '0;
            pkt_nparam  <= '0;
            pkt_params  <= '0;
        end else begin
            pkt_valid_q <= good;
            crc_fail_q  <= crc_bad;
            timeout_q   <= expire;
            frame_err_q <= rx_ferr;

            if (ld_timer)                  tmr_q <= TMR_INIT;
            else if (busy && tmr_q != '0)  tmr_q <= tmr_q - 1'b1;

            if (take) begin
                case (state_q)
                    ID: if (rx_byte != DXL_HDR) begin
                        id_q  <= rx_byte;
                        sum_q <= rx_byte;
                    end
                    LEN: begin
                        nparam_q  <= 3'(rx_byte - 8'd2);
                        sum_q     <= sum_q + rx_byte;
                        idx_q     <= '0;
                        scratch_q <= '0;
                    end
                    ERR: begin
                        err_q <= rx_byte;
                        sum_q <= sum_q + rx_byte;
                    end
                    PARAM: begin
                        scratch_q[{idx_q[1:0], 3'b000} +: 8] <= rx_byte;
                        idx_q <= idx_q + 3'd1;
                        sum_q <= sum_q + rx_byte;
                    end
                    default: ;
                endcase
            end

            if (good) begin
                pkt_id     <= id_q;
                pkt_err    <= err_q;
                pkt_nparam <= nparam_q;
                pkt_params <= scratch_q;
            end
        end
    end

    assign pkt_valid = pkt_valid_q;
    assign crc_fail  = crc_fail_q;
    assign timeout   = timeout_q;
    assign frame_err = frame_err_q;

`ifdef DXL_STATUS_RX_STATS_EN
    logic [15:0] good_cnt_q, bad_cnt_q;
    logic        bad_evt;

    // Bad = checksum, rejected length, timeout, or framing error while a packet is expected.
    assign bad_evt = crc_bad | expire | (take && state_q == LEN && !len_ok) | (rx_ferr && busy);

    always_ff @(posedge clk) begin
        if (reset) begin
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            if (good && good_cnt_q != 16'hFFFF)   good_cnt_q <= good_cnt_q + 16'd1;
            if (bad_evt && bad_cnt_q != 16'hFFFF) bad_cnt_q  <= bad_cnt_q + 16'd1;
        end
    end

    assign stat_good = good_cnt_q;
    assign stat_bad  = bad_cnt_q;
`else
    assign stat_good = '0;
    assign stat_bad  = '0;
`endif

endmodule

// File: tb/tb_dxl_status_rx.sv
// Directed bench for dxl_status_rx: serial packets in, results scoreboarded
// against expectations pushed when each packet is sent.
module tb_dxl_status_rx;

    localparam int CLK_HZ      = 16_000_000;
    localparam int BAUD        = 1_000_000;
    localparam int BIT_CYC     = CLK_HZ / BAUD;
    localparam int TIMEOUT_CYC = 4000;
`ifdef DXL_STATUS_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [2:0] K_VALID = 3'b001;
    localparam logic [2:0] K_CRC   = 3'b010;
    localparam logic [2:0] K_TO    = 3'b100;

    typedef struct packed {
        logic [2:0]  kind;
        logic [7:0]  id;
        logic [7:0]  err;
        logic [2:0]  nparam;
        logic [31:0] params;
    } res_t;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset, rxd, arm;
    logic        busy, pkt_valid, crc_fail, timeout, frame_err;
    logic [7:0]  pkt_id, pkt_err;
    logic [2:0]  pkt_nparam;
    logic [31:0] pkt_params;
    logic [15:0] stat_good, stat_bad;

    res_t exp_q[$];
    res_t obs_q[$];
    int   total = 0;
    int   bad = 0;
    int   ferr_seen = 0;

    always #5 clk = ~clk;

    dxl_status_rx #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .MAX_PARAMS(4), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .arm(arm), .busy(busy),
        .pkt_valid(pkt_valid), .crc_fail(crc_fail), .timeout(timeout), .frame_err(frame_err),
        .pkt_id(pkt_id), .pkt_err(pkt_err), .pkt_nparam(pkt_nparam), .pkt_params(pkt_params),
        .stat_good(stat_good), .stat_bad(stat_bad)
    );

    // Result monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        res_t r;
        if (frame_err) ferr_seen++;
        if (pkt_valid || crc_fail || timeout) begin
            r.kind   = {timeout, crc_fail, pkt_valid};
            r.id     = pkt_id;
            r.err    = pkt_err;
            r.nparam = pkt_nparam;
            r.params = pkt_params;
            obs_q.push_back(r);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] kind, input logic [7:0] id, input logic [7:0] err,
                            input logic [2:0] np, input logic [31:0] params);
        res_t e;
        e.kind = kind; e.id = id; e.err = err; e.nparam = np; e.params = params;
        exp_q.push_back(e);
    endtask

    task automatic expect_result(input string tag);
        res_t e, o;
        int   n = 0;
        while (obs_q.size() == 0 && n < 40 * BIT_CYC) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({tag, "_count"}, 64'(obs_q.size()), 64'd1);
        e = exp_q.pop_front();
        if (obs_q.size() != 0) begin
            o = obs_q.pop_front();
            check(tag, 64'(o), 64'(e));
        end
    endtask

    task automatic send_bit(input logic v);
        rxd = v;
        repeat (BIT_CYC) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic send_bytes(input bq_t q);
        foreach (q[i]) send_byte(q[i], 1'b1);
    endtask

    task automatic pulse_arm();
        @(posedge clk); #1 arm = 1'b1;
        @(posedge clk); #1 arm = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bq_t pkt;
        reset = 1'b1; rxd = 1'b1; arm = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Reset state
        check("rst_flags", 64'({busy, pkt_valid, crc_fail, timeout, frame_err}), 64'd0);
        check("rst_pkt", 64'({pkt_id, pkt_err, pkt_nparam, pkt_params}), 64'd0);
        check("rst_stats", 64'({stat_good, stat_bad}), 64'd0);

        // Good single-parameter packet
        pulse_arm();
        check("arm_busy", 64'(busy), 64'd1);
        push_exp(K_VALID, 8'h01, 8'h00, 3'd1, 32'h0000_0020);
        pkt = '{8'hFF, 8'hFF, 8'h01, 8'h03, 8'h00, 8'h20, 8'hDB};
        send_bytes(pkt);
        expect_result("good1");
        check("good1_idle", 64'(busy), 64'd0);

        // Bad checksum: pkt_* keep previous contents
        pulse_arm();
        push_exp(K_CRC, 8'h01, 8'h00, 3'd1, 32'h0000_0020);
        pkt = '{8'hFF, 8'hFF, 8'h01, 8'h03, 8'h00, 8'h20, 8'hDC};
        send_bytes(pkt);
        expect_result("crc");
        check("crc_stat_bad", 64'(stat_bad), STATS ? 64'd1 : 64'd0);

        // Timeout exactly TIMEOUT_CYC cycles after the arm edge
        @(posedge clk); #1 arm = 1'b1;
        @(posedge clk); #1 arm = 1'b0;
        repeat (TIMEOUT_CYC - 1) @(posedge clk);
        #1 check("to_early", 64'(timeout), 64'd0);
        push_exp(K_TO, 8'h01, 8'h00, 3'd1, 32'h0000_0020);
        @(posedge clk); #1;
        check("to_pulse", 64'(timeout), 64'd1);
        check("to_busy", 64'(busy), 64'd0);
        expect_result("to_result");

        // Extra preamble FF, zero parameters, stale P bytes cleared
        pulse_arm();
        push_exp(K_VALID, 8'hFE, 8'h04, 3'd0, 32'h0);
        pkt = '{8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'h02, 8'h04, 8'hFB};
        send_bytes(pkt);
        expect_result("extra_ff");

        // Oversized LEN dropped, parser resyncs on the next header
        pulse_arm();
        push_exp(K_VALID, 8'h01, 8'h00, 3'd0, 32'h0);
        pkt = '{8'hFF, 8'hFF, 8'h01, 8'h09, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC};
        send_bytes(pkt);
        expect_result("bad_len");

        // Framing error while armed, then a two-parameter packet
        pulse_arm();
        send_byte(8'h55, 1'b0);
        send_bit(1'b1);
        check("ferr_pulse", 64'(ferr_seen), 64'd1);
        push_exp(K_VALID, 8'h05, 8'h01, 3'd2, 32'h0000_2211);
        pkt = '{8'hFF, 8'hFF, 8'h05, 8'h04, 8'h01, 8'h11, 8'h22, 8'hC2};
        send_bytes(pkt);
        expect_result("after_ferr");

        // MAX_PARAMS boundary: LEN = 6
        pulse_arm();
        push_exp(K_VALID, 8'h07, 8'h00, 3'd4, 32'hD4C3_B2A1);
        pkt = '{8'hFF, 8'hFF, 8'h07, 8'h06, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h08};
        send_bytes(pkt);
        expect_result("max_params");
        check("stat_good", 64'(stat_good), STATS ? 64'd5 : 64'd0);
        check("stat_bad", 64'(stat_bad), STATS ? 64'd4 : 64'd0);

        // Reset in the middle of the parameter field
        pulse_arm();
        pkt = '{8'hFF, 8'hFF, 8'h02, 8'h04, 8'h00, 8'h33};
        send_bytes(pkt);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        reset = 1'b1; rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("midrst_flags", 64'({busy, pkt_valid, crc_fail, timeout, frame_err}), 64'd0);
        check("midrst_pkt", 64'({pkt_id, pkt_err, pkt_nparam, pkt_params}), 64'd0);
        check("midrst_stats", 64'({stat_good, stat_bad}), 64'd0);
        check("midrst_quiet", 64'(obs_q.size()), 64'd0);

        // Arm while busy discards the partial packet; then a clean packet parses
        pulse_arm();
        pkt = '{8'hFF, 8'hFF, 8'h09};
        send_bytes(pkt);
        pulse_arm();
        push_exp(K_VALID, 8'h01, 8'h00, 3'd1, 32'h0000_0020);
        pkt = '{8'hFF, 8'hFF, 8'h01, 8'h03, 8'h00, 8'h20, 8'hDB};
        send_bytes(pkt);
        expect_result("rearm_good");
        check("rearm_stat_good", 64'(stat_good), STATS ? 64'd1 : 64'd0);

        repeat (5 * BIT_CYC) @(posedge clk);
        #1 check("no_extra", 64'(obs_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
